// File: rtl/axi_lite_bram_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_bram_bridge_if
// Function : AXI4-Lite AW/W/B/AR/R channel bundle for axi_lite_bram_bridge.
// Revision : 1.0 - initial release
// ============================================================================
interface axi_lite_bram_bridge_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   araddr;
   logic                arvalid;
   logic [2:0]          arprot;
   logic                arready;

   logic [ADDR_W-1:0]   awaddr;
   logic                awvalid;
   logic [2:0]          awprot;
   logic                awready;

   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;

   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;

   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;

   modport slave (
      input  araddr, arvalid, arprot,
      input  awaddr, awvalid, awprot,
      input  wdata, wstrb, wvalid,
      input  rready, bready,
      output arready, awready, wready,
      output rdata, rresp, rvalid,
      output bresp, bvalid
   );

   modport master (
      output araddr, arvalid, arprot,
      output awaddr, awvalid, awprot,
      output wdata, wstrb, wvalid,
      output rready, bready,
      input  arready, awready, wready,
      input  rdata, rresp, rvalid,
      input  bresp, bvalid
   );
endinterface
`default_nettype wire

// File: rtl/axi_lite_bram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_bram_bridge
// Function : AXI4-Lite slave to single-port block-RAM bridge; one access at a
//            time, round-robin between contending reads and writes.
// Options  : BRAM_BRIDGE_RANGE_CHECK_EN - out-of-range word indices get SLVERR
//            and never reach the BRAM (default: index wraps modulo depth).
// Revision : 1.0 - initial parametrised release
// ============================================================================
module axi_lite_bram_bridge #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int BRAM_AW = 10,
   parameter int RD_LAT  = 2
) (
   input  wire                   clk,
   input  wire                   rst,
   axi_lite_bram_bridge_if.slave axi,
   output logic                  bram_clk,
   output logic                  bram_en,
   output logic [DATA_W/8-1:0]   bram_we,
   output logic [BRAM_AW-1:0]    bram_addr,
   output logic [DATA_W-1:0]     bram_din,
   input  wire  [DATA_W-1:0]     bram_dout
);

   localparam int         STRB_W      = DATA_W / 8;
   localparam int         WB          = $clog2(STRB_W);
   localparam logic [2:0] LAT         = 3'(RD_LAT);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   generate
      if (!(DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
         $error("axi_lite_bram_bridge: DATA_W must be 32 or 64");
      end
      if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
         $error("axi_lite_bram_bridge: RD_LAT must be 1..4");
      end
      if (ADDR_W < WB + BRAM_AW) begin : g_bad_addr_w
         $error("axi_lite_bram_bridge: ADDR_W too narrow for BRAM_AW");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_WAIT = 3'd1,
      S_RD_RESP = 3'd2,
      S_WR_EXEC = 3'd3,
      S_WR_RESP = 3'd4
   } state_t;

   typedef enum logic {
      PRIO_RD = 1'b0,
      PRIO_WR = 1'b1
   } prio_t;

   state_t              state_q,     state_d;
   prio_t               prio_q,      prio_d;
   logic [2:0]          cnt_q,       cnt_d;
   logic                rd_oor_q,    rd_oor_d;

   logic                aw_full_q,   aw_full_d;
   logic [BRAM_AW-1:0]  aw_idx_q,    aw_idx_d;
   logic                aw_oor_q,    aw_oor_d;
   logic                w_full_q,    w_full_d;
   logic [DATA_W-1:0]   w_data_q,    w_data_d;
   logic [STRB_W-1:0]   w_strb_q,    w_strb_d;

   logic                bram_en_q,   bram_en_d;
   logic [STRB_W-1:0]   bram_we_q,   bram_we_d;
   logic [BRAM_AW-1:0]  bram_addr_q, bram_addr_d;
   logic [DATA_W-1:0]   bram_din_q,  bram_din_d;

   logic [DATA_W-1:0]   rdata_q,     rdata_d;
   logic [1:0]          rresp_q,     rresp_d;
   logic                rvalid_q,    rvalid_d;
   logic [1:0]          bresp_q,     bresp_d;
   logic                bvalid_q,    bvalid_d;

   logic                wr_cand;
   logic                ar_ready;
   logic                aw_ready;
   logic                w_ready;
   logic                ar_oor;
   logic                aw_oor;
   logic                unused_bits;

   // Index bits above the BRAM depth mark an out-of-range access.
`ifdef BRAM_BRIDGE_RANGE_CHECK_EN
   generate
      if (ADDR_W > WB + BRAM_AW) begin : g_range_chk
         assign ar_oor = |axi.araddr[ADDR_W-1:WB+BRAM_AW];
         assign aw_oor = |axi.awaddr[ADDR_W-1:WB+BRAM_AW];
      end else begin : g_no_range_bits
         assign ar_oor = 1'b0;
         assign aw_oor = 1'b0;
      end
   endgenerate
`else
   assign ar_oor = 1'b0;
   assign aw_oor = 1'b0;
`endif

   assign unused_bits = &{1'b0, axi.arprot, axi.awprot, axi.araddr, axi.awaddr};

   assign wr_cand  = aw_full_q && w_full_q;
   assign ar_ready = !rst && (state_q == S_IDLE) && !(wr_cand && (prio_q == PRIO_WR));
   assign aw_ready = !rst && !aw_full_q;
   assign w_ready  = !rst && !w_full_q;

   always_comb begin
      state_d     = state_q;
      prio_d      = prio_q;
      cnt_d       = cnt_q;
      rd_oor_d    = rd_oor_q;
      aw_full_d   = aw_full_q;
      aw_idx_d    = aw_idx_q;
      aw_oor_d    = aw_oor_q;
      w_full_d    = w_full_q;
      w_data_d    = w_data_q;
      w_strb_d    = w_strb_q;
      bram_en_d   = 1'b0;
      bram_we_d   = '0;
      bram_addr_d = bram_addr_q;
      bram_din_d  = bram_din_q;
      rdata_d     = rdata_q;
      rresp_d     = rresp_q;
      rvalid_d    = rvalid_q;
      bresp_d     = bresp_q;
      bvalid_d    = bvalid_q;

      // Write buffers fill independently of the access state machine.
      if (axi.awvalid && aw_ready) begin
         aw_full_d = 1'b1;
         aw_idx_d  = axi.awaddr[WB +: BRAM_AW];
         aw_oor_d  = aw_oor;
      end
      if (axi.wvalid && w_ready) begin
         w_full_d = 1'b1;
         w_data_d = axi.wdata;
         w_strb_d = axi.wstrb;
      end

      case (state_q)
         S_IDLE: begin
            if (axi.arvalid && ar_ready) begin
               state_d     = S_RD_WAIT;
               prio_d      = PRIO_WR;
               cnt_d       = 3'd0;
               rd_oor_d    = ar_oor;
               bram_en_d   = !ar_oor;
               bram_addr_d = axi.araddr[WB +: BRAM_AW];
            end else if (wr_cand && (prio_q == PRIO_WR || !axi.arvalid)) begin
               state_d     = S_WR_EXEC;
               prio_d      = PRIO_RD;
               bram_en_d   = !aw_oor_q;
               bram_we_d   = aw_oor_q ? '0 : w_strb_q;
               bram_addr_d = aw_idx_q;
               bram_din_d  = w_data_q;
            end
         end

         S_RD_WAIT: begin
            // Count covers the address cycle plus RD_LAT BRAM pipeline stages.
            if (cnt_q == LAT) begin
               state_d  = S_RD_RESP;
               rvalid_d = 1'b1;
               rdata_d  = rd_oor_q ? '0 : bram_dout;
               rresp_d  = rd_oor_q ? RESP_SLVERR : RESP_OKAY;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end

         S_RD_RESP: begin
            if (axi.rready) begin
               rvalid_d = 1'b0;
               state_d  = S_IDLE;
            end
         end

         S_WR_EXEC: begin
            state_d  = S_WR_RESP;
            bvalid_d = 1'b1;
            bresp_d  = aw_oor_q ? RESP_SLVERR : RESP_OKAY;
         end

         S_WR_RESP: begin
            if (axi.bready) begin
               bvalid_d  = 1'b0;
               aw_full_d = 1'b0;
               w_full_d  = 1'b0;
               state_d   = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         prio_q      <= PRIO_RD;
         cnt_q       <= 3'd0;
         rd_oor_q    <= 1'b0;
         aw_full_q   <= 1'b0;
         aw_idx_q    <= '0;
         aw_oor_q    <= 1'b0;
         w_full_q    <= 1'b0;
         w_data_q    <= '0;
         w_strb_q    <= '0;
         bram_en_q   <= 1'b0;
         bram_we_q   <= '0;
         bram_addr_q <= '0;
         bram_din_q  <= '0;
         rdata_q     <= '0;
         rresp_q     <= 2'b00;
         rvalid_q    <= 1'b0;
         bresp_q     <= 2'b00;
         bvalid_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         prio_q      <= prio_d;
         cnt_q       <= cnt_d;
         rd_oor_q    <= rd_oor_d;
         aw_full_q   <= aw_full_d;
         aw_idx_q    <= aw_idx_d;
         aw_oor_q    <= aw_oor_d;
         w_full_q    <= w_full_d;
         w_data_q    <= w_data_d;
         w_strb_q    <= w_strb_d;
         bram_en_q   <= bram_en_d;
         bram_we_q   <= bram_we_d;
         bram_addr_q <= bram_addr_d;
         bram_din_q  <= bram_din_d;
         rdata_q     <= rdata_d;
         rresp_q     <= rresp_d;
         rvalid_q    <= rvalid_d;
         bresp_q     <= bresp_d;
         bvalid_q    <= bvalid_d;
      end
   end

   assign bram_clk    = clk;
   assign bram_en     = bram_en_q;
   assign bram_we     = bram_we_q;
   assign bram_addr   = bram_addr_q;
   assign bram_din    = bram_din_q;

   assign axi.arready = ar_ready;
   assign axi.awready = aw_ready;
   assign axi.wready  = w_ready;
   assign axi.rdata   = rdata_q;
   assign axi.rresp   = rresp_q;
   assign axi.rvalid  = rvalid_q;
   assign axi.bresp   = bresp_q;
   assign axi.bvalid  = bvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_bram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_bram_bridge
// Function : Self-checking bench for axi_lite_bram_bridge (DATA_W=32,
//            BRAM_AW=10, RD_LAT=2); honours BRAM_BRIDGE_RANGE_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_bram_bridge;

   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 32;
   localparam int BRAM_AW = 10;
   localparam int RD_LAT  = 2;
   localparam int DEPTH   = 1 << BRAM_AW;
   localparam int TO      = 200;

`ifdef BRAM_BRIDGE_RANGE_CHECK_EN
   localparam logic [31:0] X_RD1000 = 32'h0000_0000;
   localparam logic [1:0]  X_RESP   = 2'b10;
   localparam int          X_EN     = 0;
   localparam logic [31:0] X_RD08   = 32'h0000_0000;
`else
   localparam logic [31:0] X_RD1000 = 32'h1357_9BDF;
   localparam logic [1:0]  X_RESP   = 2'b00;
   localparam int          X_EN     = 1;
   localparam logic [31:0] X_RD08   = 32'h0BAD_F00D;
`endif

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                bram_clk;
   logic                bram_en;
   logic [3:0]          bram_we;
   logic [BRAM_AW-1:0]  bram_addr;
   logic [DATA_W-1:0]   bram_din;
   logic [DATA_W-1:0]   bram_dout;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   axi_lite_bram_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

   axi_lite_bram_bridge #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .BRAM_AW (BRAM_AW),
      .RD_LAT  (RD_LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .axi       (axi),
      .bram_clk  (bram_clk),
      .bram_en   (bram_en),
      .bram_we   (bram_we),
      .bram_addr (bram_addr),
      .bram_din  (bram_din),
      .bram_dout (bram_dout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // BRAM stub with RD_LAT-stage read pipeline, plus access monitors.
   logic [31:0]  mem  [DEPTH];
   logic [31:0]  pipe [RD_LAT];
   int           en_cnt = 0;
   int           we_cnt = 0;
   int           we_no_en = 0;
   logic [9:0]   last_addr = '0;
   byte          acc_log [$];

   always @(posedge bram_clk) begin
      if (bram_en) begin
         pipe[0] <= mem[bram_addr];
         for (int b = 0; b < 4; b++)
            if (bram_we[b]) mem[bram_addr][8*b +: 8] = bram_din[8*b +: 8];
         en_cnt++;
         last_addr = bram_addr;
         if (bram_we != 4'h0) we_cnt++;
         acc_log.push_back((bram_we != 4'h0) ? 8'h57 : 8'h52);
      end else if (bram_we != 4'h0) begin
         we_no_en++;
      end
      for (int k = RD_LAT - 1; k > 0; k--) pipe[k] <= pipe[k-1];
   end
   assign bram_dout = pipe[RD_LAT-1];

   // Reference model: byte-addressed memory image computed from the AXI view.
   logic [31:0] ref_mem [DEPTH];

   function automatic bit is_oor(input logic [31:0] a);
`ifdef BRAM_BRIDGE_RANGE_CHECK_EN
      return a[31:12] != 20'h0;
`else
      return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) % DEPTH);
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      if (!is_oor(a))
         for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[widx(a)][8*b +: 8] = d[8*b +: 8];
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string what);
      n_tests++;
      n_fail++;
      $display("FAIL timeout %s: actual none required within %0d cycles", what, TO);
   endtask

   // All channel tasks start and return on a falling edge.
   task automatic send_aw(input logic [31:0] a, output int hs);
      int n = 0;
      axi.awaddr = a; axi.awprot = 3'($urandom); axi.awvalid = 1'b1;
      #1;
      while (!axi.awready && n < TO) begin @(negedge clk); #1; n++; end
      if (!axi.awready) begin timeout_fail("aw"); hs = -100; end
      else hs = cyc + 1;
      @(negedge clk); axi.awvalid = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] d, input logic [3:0] s, output int hs);
      int n = 0;
      axi.wdata = d; axi.wstrb = s; axi.wvalid = 1'b1;
      #1;
      while (!axi.wready && n < TO) begin @(negedge clk); #1; n++; end
      if (!axi.wready) begin timeout_fail("w"); hs = -100; end
      else hs = cyc + 1;
      @(negedge clk); axi.wvalid = 1'b0;
   endtask

   task automatic send_ar(input logic [31:0] a, output int hs);
      int n = 0;
      axi.araddr = a; axi.arprot = 3'($urandom); axi.arvalid = 1'b1;
      #1;
      while (!axi.arready && n < TO) begin @(negedge clk); #1; n++; end
      if (!axi.arready) begin timeout_fail("ar"); hs = -100; end
      else hs = cyc + 1;
      @(negedge clk); axi.arvalid = 1'b0;
   endtask

   task automatic recv_b(output logic [1:0] r, output int rise);
      int n = 0;
      axi.bready = 1'b1;
      #1;
      while (!axi.bvalid && n < TO) begin @(negedge clk); #1; n++; end
      if (!axi.bvalid) begin timeout_fail("b"); rise = -100; r = 2'bxx; end
      else begin rise = cyc; r = axi.bresp; end
      @(negedge clk); axi.bready = 1'b0;
   endtask

   task automatic recv_r(output logic [31:0] d, output logic [1:0] r, output int rise);
      int n = 0;
      axi.rready = 1'b1;
      #1;
      while (!axi.rvalid && n < TO) begin @(negedge clk); #1; n++; end
      if (!axi.rvalid) begin timeout_fail("r"); rise = -100; d = 'x; r = 2'bxx; end
      else begin rise = cyc; d = axi.rdata; r = axi.rresp; end
      @(negedge clk); axi.rready = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int w_gap, input logic [1:0] exp_resp, input int exp_en);
      int ah, wh, rise, en0;
      logic [1:0] br;
      en0 = en_cnt;
      if (w_gap == 0) begin
         fork
            begin send_aw(a, ah); end
            begin send_w(d, s, wh); end
         join
      end else begin
         send_w(d, s, wh);
         repeat (w_gap - 1) @(negedge clk);
         send_aw(a, ah);
      end
      recv_b(br, rise);
      check("bresp", 64'(br), 64'(exp_resp));
      check("b_latency", 64'(rise - ((ah > wh) ? ah : wh)), 64'd2);
      check("wr_bram_en_count", 64'(en_cnt - en0), 64'(exp_en));
      model_write(a, d, s);
   endtask

   task automatic do_read(input logic [31:0] a, input logic [31:0] exp_d, input logic [1:0] exp_resp,
                          input int exp_en, input logic [9:0] exp_baddr);
      int ah, rise, en0;
      logic [31:0] d;
      logic [1:0] r;
      en0 = en_cnt;
      send_ar(a, ah);
      recv_r(d, r, rise);
      check("rdata", 64'(d), 64'(exp_d));
      check("rresp", 64'(r), 64'(exp_resp));
      check("r_latency", 64'(rise - ah), 64'(RD_LAT + 1));
      check("rd_bram_en_count", 64'(en_cnt - en0), 64'(exp_en));
      if (exp_en == 1) check("rd_bram_addr", 64'(last_addr), 64'(exp_baddr));
   endtask

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_resp;
      int          exp_en;
      logic [9:0]  exp_baddr;
   } vec_t;

   vec_t vecs [11];
   byte  exp_order [4] = '{8'h52, 8'h57, 8'h52, 8'h57};

   initial begin
      #500000;
      $display("FAIL watchdog: actual no finish required finish before 500000");
      $fatal(1, "watchdog");
   end

   initial begin
      int ah, wh, rise, we0, n;
      logic [31:0] held;
      logic [1:0] br;

      for (int i = 0; i < DEPTH; i++) begin mem[i] = '0; ref_mem[i] = '0; end
      for (int k = 0; k < RD_LAT; k++) pipe[k] = '0;
      axi.arvalid = 1'b0; axi.araddr = '0; axi.arprot = '0;
      axi.awvalid = 1'b0; axi.awaddr = '0; axi.awprot = '0;
      axi.wvalid  = 1'b0; axi.wdata  = '0; axi.wstrb  = '0;
      axi.rready  = 1'b0; axi.bready = 1'b0;

      vecs[0]  = '{1'b1, 32'h0000_0000, 32'h1357_9BDF, 4'hF, 32'h0,         2'b00,  1,    10'd0};
      vecs[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         2'b00,  1,    10'd4};
      vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 2'b00,  1,    10'd4};
      vecs[3]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0,         2'b00,  1,    10'd8};
      vecs[4]  = '{1'b1, 32'h0000_0020, 32'h0000_00AA, 4'h1, 32'h0,         2'b00,  1,    10'd8};
      vecs[5]  = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h1122_33AA, 2'b00,  1,    10'd8};
      vecs[6]  = '{1'b1, 32'h0000_0027, 32'hCAFE_F00D, 4'hC, 32'h0,         2'b00,  1,    10'd9};
      vecs[7]  = '{1'b0, 32'h0000_0024, 32'h0,         4'h0, 32'hCAFE_0000, 2'b00,  1,    10'd9};
      vecs[8]  = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, X_RD1000,      X_RESP, X_EN, 10'd0};
      vecs[9]  = '{1'b1, 32'h0000_1008, 32'h0BAD_F00D, 4'hF, 32'h0,         X_RESP, X_EN, 10'd2};
      vecs[10] = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, X_RD08,        2'b00,  1,    10'd2};

      // Reset state
      @(negedge clk); #1;
      check("rst_readies", 64'({axi.arready, axi.awready, axi.wready}), 64'd0);
      check("rst_valids_en_we", 64'({axi.rvalid, axi.bvalid, bram_en, bram_we}), 64'd0);
      check("rst_rdata_resp", 64'({axi.rdata, axi.rresp, axi.bresp}), 64'd0);
      check("rst_bram_addr_din", 64'({bram_addr, bram_din}), 64'd0);
      @(negedge clk); rst = 1'b0; #1;
      check("readies_after_rst", 64'({axi.arready, axi.awready, axi.wready}), 64'd7);
      @(negedge clk);

      // Directed vector table
      for (int i = 0; i < 11; i++) begin
         if (vecs[i].wr)
            do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, vecs[i].exp_resp, vecs[i].exp_en);
         else
            do_read(vecs[i].addr, vecs[i].exp_rdata, vecs[i].exp_resp, vecs[i].exp_en, vecs[i].exp_baddr);
      end

      // W leads AW by three cycles
      we0 = we_cnt;
      send_w(32'h5566_7788, 4'hF, wh);
      #1;
      check("wready_low_after_w", 64'(axi.wready), 64'd0);
      repeat (3) @(negedge clk);
      check("no_we_before_aw", 64'(we_cnt - we0), 64'd0);
      send_aw(32'h0000_0050, ah);
      recv_b(br, rise);
      check("w_first_bresp", 64'(br), 64'd0);
      check("w_first_b_latency", 64'(rise - ah), 64'd2);
      #1;
      check("aw_w_ready_after_b", 64'({axi.awready, axi.wready}), 64'd3);
      @(negedge clk);
      model_write(32'h0000_0050, 32'h5566_7788, 4'hF);
      do_read(32'h0000_0050, 32'h5566_7788, 2'b00, 1, 10'd20);

      // Read stalled by rready low for five cycles
      do_write(32'h0000_0030, 32'hA5A5_0F0F, 4'hF, 0, 2'b00, 1);
      send_ar(32'h0000_0030, ah);
      n = 0; #1;
      while (!axi.rvalid && n < TO) begin @(negedge clk); #1; n++; end
      held = axi.rdata;
      check("stall_rdata", 64'(held), 64'hA5A5_0F0F);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         check("stall_rvalid_rdata_arready", 64'({axi.rvalid, axi.rdata, axi.arready}),
               64'({1'b1, held, 1'b0}));
      end
      axi.rready = 1'b1;
      @(negedge clk); axi.rready = 1'b0; #1;
      check("arready_after_r", 64'({axi.rvalid, axi.arready}), 64'd1);
      @(negedge clk);

      // Reset during RD_WAIT
      send_ar(32'h0000_0030, ah);
      rst = 1'b1; #1;
      check("midrst_readies", 64'({axi.arready, axi.awready, axi.wready}), 64'd0);
      check("midrst_valids_en_we", 64'({axi.rvalid, axi.bvalid, bram_en, bram_we}), 64'd0);
      check("midrst_rdata_addr", 64'({axi.rdata, bram_addr}), 64'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0; #1;
      check("readies_after_midrst", 64'({axi.arready, axi.awready, axi.wready}), 64'd7);
      repeat (RD_LAT + 3) @(negedge clk);
      check("no_rvalid_after_abort", 64'(axi.rvalid), 64'd0);

      // Contending read and write after reset: round-robin from read
      @(negedge clk); rst = 1'b1;
      repeat (2) @(negedge clk); rst = 1'b0;
      acc_log.delete();
      fork
         begin
            logic [31:0] d;
            logic [1:0] r;
            int h, rr;
            for (int j = 0; j < 2; j++) begin
               send_ar(32'h0000_0040 + 32'(4 * j), h);
               recv_r(d, r, rr);
               check("arb_rdata", 64'(d), 64'(ref_mem[16 + j]));
            end
         end
         begin
            logic [1:0] b;
            int ha, hw, rb;
            for (int j = 0; j < 2; j++) begin
               fork
                  begin send_aw(32'h0000_0048 + 32'(4 * j), ha); end
                  begin send_w(32'h7700_0000 + 32'(j), 4'hF, hw); end
               join
               recv_b(b, rb);
               model_write(32'h0000_0048 + 32'(4 * j), 32'h7700_0000 + 32'(j), 4'hF);
            end
         end
      join
      check("arb_access_count", 64'(acc_log.size()), 64'd4);
      for (int j = 0; j < 4; j++)
         if (j < acc_log.size()) check("arb_order", 64'(acc_log[j]), 64'(exp_order[j]));

      // Randomised traffic against the reference model
      for (int i = 0; i < 40; i++) begin
         logic [31:0] a, d;
         logic [3:0] s;
         a = {20'h0, 5'h0, 5'($urandom_range(0, 31)), 2'($urandom)};
         if ($urandom_range(0, 5) == 0) a[31:12] = 20'($urandom_range(1, 15));
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom;
            s = 4'($urandom);
            do_write(a, d, s, int'($urandom_range(0, 3)), is_oor(a) ? 2'b10 : 2'b00,
                     is_oor(a) ? 0 : 1);
         end else begin
            do_read(a, is_oor(a) ? 32'h0 : ref_mem[widx(a)], is_oor(a) ? 2'b10 : 2'b00,
                    is_oor(a) ? 0 : 1, 10'(widx(a)));
         end
      end

      check("we_without_en", 64'(we_no_en), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/axi_lite_bram_bridge.md
# axi_lite_bram_bridge

Parametrised AXI4-Lite slave to single-port block-RAM bridge, the successor to the fixed 32-bit bridge. Accepts independent AW/W/AR channels, converts byte addresses to word indices and performs one access at a time with a configurable BRAM read latency. When a read and a write contend, round-robin arbitration alternates between them. Sits between the core's AXI interconnect and an inferred or IP block RAM.

## Interface
- DATA_W, 32, AXI/BRAM data width; 32 or 64
- ADDR_W, 32, AXI byte-address width
- BRAM_AW, 10, BRAM word-address width (depth = 2^BRAM_AW words)
- RD_LAT, 2, BRAM read latency in clocks, 1..4
- clk  in  1  clock; also drives bram_clk
- rst  in  1  asynchronous, active-high reset
- bram_clk  out  1  = clk
- bram_en  out  1  BRAM enable, pulsed per access
- bram_we  out  DATA_W/8  byte write enables
- bram_addr  out  BRAM_AW  word address
- bram_din  out  DATA_W  write data
- bram_dout  in  DATA_W  read data
- axi_araddr/arvalid/arprot, axi_awaddr/awvalid/awprot, axi_wdata/wstrb/wvalid, axi_rready, axi_bready  in  AXI4-Lite slave inputs; prot ignored
- axi_arready, axi_awready, axi_wready, axi_rdata, axi_rresp, axi_rvalid, axi_bresp, axi_bvalid  out  AXI4-Lite slave outputs

## Operation
- Word index = addr[ADDR_W-1 : log2(DATA_W/8)]; low bits ignored; bram_addr = lower BRAM_AW bits of index.
- AW buffer and W buffer are independent single-entry registers; awready = !aw_full, wready = !w_full; they fill in any state, including during reads.
- Write candidate = aw_full && w_full. Read candidate = arvalid.
- States: IDLE, RD_WAIT, RD_RESP, WR_EXEC, WR_RESP.
- arready = (state==IDLE) && !(write candidate && prio==WR).
- IDLE: AR handshake → RD_WAIT. Otherwise, if write candidate and (prio==WR or !arvalid) → WR_EXEC.
- prio flips to the other type after each served access; reset value RD.
- RD_WAIT: bram_en=1 with address in the first cycle; counter runs RD_LAT cycles, then bram_dout is captured into axi_rdata → RD_RESP.
- RD_RESP: rvalid=1; rdata and rresp held stable until rready; on handshake → IDLE.
- WR_EXEC: exactly one cycle of bram_en=1, bram_we=wstrb, bram_din=wdata → WR_RESP.
- WR_RESP: bvalid=1 until bready. On handshake, both buffers clear → IDLE.
- Reset, asynchronous: state IDLE, buffers empty, prio RD. bram_en/we/addr/din, rdata, rresp, bresp, rvalid and bvalid all 0. All readies forced 0 while rst is high and return to 1 in the first cycle after deassertion.
- Reset asserted mid-transaction aborts it. No response is issued and no BRAM write completes.

## Timing
- Read: AR handshake at edge E0. bram_en is high in cycle E0..E1. bram_dout is sampled at edge E0+RD_LAT+1. rvalid is high from that edge. Read-to-rvalid latency = RD_LAT+1 cycles.
- Write: final AW/W capture at edge E0. WR_EXEC runs in the cycle after, when write wins arbitration, and bvalid rises one edge later. Minimum AW/W-to-bvalid = 2 cycles.
- awready/wready reassert in the cycle after the B handshake. arready reasserts in the cycle after the R handshake.
- Back-to-back: a new access can start in the cycle after any response handshake.
- bram_we is nonzero only in WR_EXEC.

## Configuration
- BRAM_BRIDGE_RANGE_CHECK_EN defined: an index with nonzero bits above BRAM_AW is out of range.
  - Out-of-range read: rresp=2'b10 (SLVERR), rdata=0, bram_en stays 0, latency unchanged.
  - Out-of-range write: bresp=2'b10, bram_en and bram_we stay 0.
- Undefined: the upper bits are truncated and the address wraps modulo depth. rresp and bresp are always 2'b00.

## Test plan
All scenarios use DATA_W=32, BRAM_AW=10, RD_LAT=2.
- Write 0xDEADBEEF to 0x10 with wstrb 0xF, then read 0x10 → rdata 0xDEADBEEF, rresp 0, rvalid 3 cycles after the AR handshake, bram_addr=4.
- Preload 0x11223344 at 0x20, write 0x000000AA with wstrb 0x1, read back → 0x112233AA.
- W arrives 3 cycles before AW → wready low after the W capture, no bram_we until AW is captured, bvalid 2 cycles after the AW handshake, awready and wready both high after bready.
- After reset, hold arvalid and a complete write pending together for 4 accesses → serving order is read, write, read, write.
- Read 0x1000 → with the macro defined: rresp 2'b10, rdata 0, bram_en never high. With the macro undefined: word 0 is returned, rresp 0.
- Hold rready low for 5 cycles → rvalid and rdata stable, arready 0. Assert rst mid-RD_WAIT → rvalid stays 0, all outputs reach their reset values immediately, and readies return 1 after release.
